// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the five-stage MIPS core:
// control-bundle layout, exception codes and the reset PC.
package pipe_stage_reg_pkg;

  // Control bundle bit positions, low to high.
  localparam int CTRL_MEM_WRITE   = 0;
  localparam int CTRL_REG_WRITE   = 1;
  localparam int CTRL_MEM_TO_REG  = 2;
  localparam int CTRL_ALU_SRC     = 3;
  localparam int CTRL_REG_DST_LSB = 4;   // 2 bits
  localparam int CTRL_BRANCH      = 6;
  localparam int CTRL_JUMP        = 7;
  localparam int CTRL_TNEW_LSB    = 8;   // 3 bits
  localparam int CTRL_TNEW_W      = 3;
  localparam int CTRL_TUSE_RS_LSB = 11;  // 2 bits
  localparam int CTRL_TUSE_RT_LSB = 13;  // 2 bits
  localparam int CTRL_ALU_OP_LSB  = 15;  // 4 bits
  localparam int CTRL_EXT_OP_LSB  = 19;  // 2 bits
  localparam int CTRL_MEM_SZ_LSB  = 21;  // 3 bits
  localparam int CTRL_LINK        = 24;
  localparam int CTRL_MUL_DIV_LSB = 25;  // 3 bits
  localparam int CTRL_CMP_OP_LSB  = 28;  // 3 bits
  localparam int CTRL_LEN         = 31;

  localparam int EXC_LEN = 5;

  typedef enum logic [EXC_LEN-1:0] {
    EXC_NONE = 5'd0,
    EXC_INT  = 5'd1,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/pipe_stage_reg_tnew_sat_dec.sv
// Saturating decrement of a Tnew field: counts down toward zero and stays there.
module tnew_sat_dec
  import pipe_stage_reg_pkg::*;
#(
  parameter int W = CTRL_TNEW_W
) (
  input  logic [W-1:0] tnew_in,
  output logic [W-1:0] tnew_out
);

  assign tnew_out = (tnew_in == '0) ? '0 : tnew_in - W'(1);

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid bit, bubble/flush injection, exception and
// delay-slot sideband, Tnew ageing and a consecutive-stall watchdog.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int          CTRL_W           = CTRL_LEN,
  parameter int          TNEW_LSB         = CTRL_TNEW_LSB,
  parameter int          TNEW_W           = CTRL_TNEW_W,
  parameter int          EXC_W            = EXC_LEN,
  parameter logic [31:0] RESET_PC         = RESET_PC_DEFAULT,
  parameter int          TNEW_MODE        = 0,
  parameter int          KEEP_PC_ON_FLUSH = 1,
  parameter int unsigned STALL_MAX        = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ValidIn,
  input  logic [31:0]       InsIn,
  input  logic [31:0]       PCIn,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic [EXC_W-1:0]  ExcIn,
  input  logic              BdIn,
  output logic              ValidOut,
  output logic [31:0]       InsOut,
  output logic [31:0]       PCOut,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic [EXC_W-1:0]  ExcOut,
  output logic              BdOut,
  output logic [7:0]        StallCnt,
  output logic              StallTimeout
);

  localparam int TNEW_MSB = TNEW_LSB + TNEW_W - 1;

  logic              valid_q;
  logic [31:0]       ins_q;
  logic [31:0]       pc_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [EXC_W-1:0]  exc_q;
  logic              bd_q;
  logic [7:0]        stall_cnt_q;
  logic              timeout_q;

  logic [TNEW_W-1:0] dec_in;
  logic [TNEW_W-1:0] dec_out;
  logic [CTRL_W-1:0] ctrl_load;
  logic [31:0]       bubble_pc;
  logic              bubble_bd;
  logic              take_bubble;
  logic [7:0]        stall_cnt_inc;

  // One decrementer serves both modes: on the capture path in mode 1, on the output path in mode 0.
  assign dec_in = (TNEW_MODE == 1) ? CtrlIn[TNEW_MSB:TNEW_LSB] : ctrl_q[TNEW_MSB:TNEW_LSB];

  tnew_sat_dec #(.W(TNEW_W)) u_tnew_dec (
    .tnew_in  (dec_in),
    .tnew_out (dec_out)
  );

  // NOTE: every always_comb target gets a full default first so no latch can be inferred.
  always_comb begin
    ctrl_load = CtrlIn;
    if (TNEW_MODE == 1) ctrl_load[TNEW_MSB:TNEW_LSB] = dec_out;
  end

  always_comb begin
    CtrlOut = ctrl_q;
    if (TNEW_MODE == 0) CtrlOut[TNEW_MSB:TNEW_LSB] = dec_out;
  end

  assign bubble_pc     = (KEEP_PC_ON_FLUSH != 0) ? PCIn : RESET_PC;
  assign bubble_bd     = (KEEP_PC_ON_FLUSH != 0) ? BdIn : 1'b0;
  assign take_bubble   = Flush | (~Stall & ~ValidIn);
  assign stall_cnt_inc = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;

  // NOTE: reset is synchronous here, so it is tested inside the clocked block, not in the sensitivity list.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      ins_q   <= '0;
      pc_q    <= RESET_PC;
      ctrl_q  <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
    end else if (take_bubble) begin
      valid_q <= 1'b0;
      ins_q   <= '0;
      pc_q    <= bubble_pc;
      ctrl_q  <= '0;
      exc_q   <= '0;
      bd_q    <= bubble_bd;
    end else if (!Stall) begin
      valid_q <= 1'b1;
      ins_q   <= InsIn;
      pc_q    <= PCIn;
      ctrl_q  <= ctrl_load;
      exc_q   <= ExcIn;
      bd_q    <= BdIn;
    end
  end

  // A held edge is one with Stall and no Flush; anything else restarts the watchdog.
  always_ff @(posedge Clk) begin
    if (Reset || Flush || !Stall) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_inc;
      timeout_q   <= ({24'd0, stall_cnt_inc} >= STALL_MAX);
    end
  end

  assign ValidOut     = valid_q;
  assign InsOut       = ins_q;
  assign PCOut        = pc_q;
  assign ExcOut       = exc_q;
  assign BdOut        = bd_q;
  assign StallCnt     = stall_cnt_q;
  assign StallTimeout = timeout_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (Tnew mode 0 / keep PC / STALL_MAX 4, and
// Tnew mode 1 / reset PC on bubble / STALL_MAX 255) checked against a scoreboard model.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [30:0] ctrl;
    logic [4:0]  exc;
    logic        bd;
    logic [7:0]  cnt;
    logic        tmo;
  } obs_t;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, ValidIn, BdIn;
  logic [31:0] InsIn, PCIn;
  logic [30:0] CtrlIn;
  logic [4:0]  ExcIn;

  logic        a_valid, a_bd, a_tmo, b_valid, b_bd, b_tmo;
  logic [31:0] a_ins, a_pc, b_ins, b_pc;
  logic [30:0] a_ctrl, b_ctrl;
  logic [4:0]  a_exc, b_exc;
  logic [7:0]  a_cnt, b_cnt;

  int   total = 0;
  int   bad   = 0;
  obs_t ma, mb;
  obs_t qa[$];
  obs_t qb[$];

  always #5 Clk = ~Clk;

  pipe_stage_reg #(.TNEW_MODE(0), .KEEP_PC_ON_FLUSH(1), .STALL_MAX(4)) u_a (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .InsIn(InsIn), .PCIn(PCIn), .CtrlIn(CtrlIn), .ExcIn(ExcIn), .BdIn(BdIn),
    .ValidOut(a_valid), .InsOut(a_ins), .PCOut(a_pc), .CtrlOut(a_ctrl),
    .ExcOut(a_exc), .BdOut(a_bd), .StallCnt(a_cnt), .StallTimeout(a_tmo)
  );

  pipe_stage_reg #(.TNEW_MODE(1), .KEEP_PC_ON_FLUSH(0), .STALL_MAX(255)) u_b (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .InsIn(InsIn), .PCIn(PCIn), .CtrlIn(CtrlIn), .ExcIn(ExcIn), .BdIn(BdIn),
    .ValidOut(b_valid), .InsOut(b_ins), .PCOut(b_pc), .CtrlOut(b_ctrl),
    .ExcOut(b_exc), .BdOut(b_bd), .StallCnt(b_cnt), .StallTimeout(b_tmo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one instance across one rising edge, from the current inputs.
  function automatic obs_t model_step(input obs_t cur, input bit keep, input int unsigned smax);
    obs_t n;
    int   t;
    n = cur;
    if (Reset) begin
      n = '0;
      n.pc = 32'h0000_3000;
    end else if (Flush || (!Stall && !ValidIn)) begin
      n.valid = 1'b0;
      n.ins   = '0;
      n.ctrl  = '0;
      n.exc   = '0;
      n.pc    = keep ? PCIn : 32'h0000_3000;
      n.bd    = keep ? BdIn : 1'b0;
      n.cnt   = '0;
      n.tmo   = 1'b0;
    end else if (Stall) begin
      n.cnt = (cur.cnt == 8'd255) ? 8'd255 : cur.cnt + 8'd1;
      n.tmo = (int'(n.cnt) >= int'(smax));
    end else begin
      t = int'(CtrlIn[10:8]);
      n.valid     = 1'b1;
      n.ins       = InsIn;
      n.pc        = PCIn;
      n.ctrl      = CtrlIn;
      n.ctrl[10:8] = (t > 0) ? 3'(t - 1) : 3'd0;
      n.exc       = ExcIn;
      n.bd        = BdIn;
      n.cnt       = '0;
      n.tmo       = 1'b0;
    end
    return n;
  endfunction

  task automatic compare(input string who, input obs_t got, input obs_t exp);
    check({who, ".valid"}, 32'(got.valid), 32'(exp.valid));
    check({who, ".ins"},   got.ins,        exp.ins);
    check({who, ".pc"},    got.pc,         exp.pc);
    check({who, ".ctrl"},  32'(got.ctrl),  32'(exp.ctrl));
    check({who, ".exc"},   32'(got.exc),   32'(exp.exc));
    check({who, ".bd"},    32'(got.bd),    32'(exp.bd));
    check({who, ".cnt"},   32'(got.cnt),   32'(exp.cnt));
    check({who, ".tmo"},   32'(got.tmo),   32'(exp.tmo));
  endtask

  task automatic drive(input logic rst, input logic stall, input logic flush, input logic vin,
                       input logic [31:0] ins, input logic [31:0] pc, input logic [30:0] ctrl,
                       input logic [4:0] exc, input logic bd);
    obs_t ga, gb;
    @(negedge Clk);
    Reset = rst; Stall = stall; Flush = flush; ValidIn = vin;
    InsIn = ins; PCIn = pc; CtrlIn = ctrl; ExcIn = exc; BdIn = bd;
    ma = model_step(ma, 1'b1, 4);
    mb = model_step(mb, 1'b0, 255);
    qa.push_back(ma);
    qb.push_back(mb);
    @(posedge Clk);
    #1;
    ga = '{a_valid, a_ins, a_pc, a_ctrl, a_exc, a_bd, a_cnt, a_tmo};
    gb = '{b_valid, b_ins, b_pc, b_ctrl, b_exc, b_bd, b_cnt, b_tmo};
    compare("a", ga, qa.pop_front());
    compare("b", gb, qb.pop_front());
  endtask

  function automatic logic [30:0] mk_ctrl(input logic [2:0] t);
    logic [30:0] r;
    r = 31'($urandom);
    r[10:8] = t;
    return r;
  endfunction

  task automatic load(input logic [31:0] pc, input logic [2:0] t);
    drive(1'b0, 1'b0, 1'b0, 1'b1, $urandom, pc, mk_ctrl(t), 5'($urandom), 1'($urandom));
  endtask

  task automatic stall_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'($urandom), $urandom, $urandom, mk_ctrl(3'($urandom)),
          5'($urandom), 1'($urandom));
  endtask

  initial begin
    ma = '0;
    mb = '0;
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; ValidIn = 1'b0;
    InsIn = '0; PCIn = '0; CtrlIn = '0; ExcIn = '0; BdIn = 1'b0;

    // Reset with arbitrary other inputs, including Stall and Flush.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 31'h7FFF_FFFF, 5'd12, 1'b1);
    check("rst_pc", a_pc, 32'h0000_3000);
    check("rst_cnt", 32'(b_cnt), 32'd0);

    // Tnew ageing in both modes, including saturation at zero.
    load(32'h0000_3000, 3'd2);
    check("tnew2_a", 32'(a_ctrl[10:8]), 32'd1);
    check("tnew2_b", 32'(b_ctrl[10:8]), 32'd1);
    load(32'h0000_3004, 3'd0);
    check("tnew0_a", 32'(a_ctrl[10:8]), 32'd0);
    check("tnew0_b", 32'(b_ctrl[10:8]), 32'd0);
    load(32'h0000_3008, 3'd7);

    // Stall hold while inputs keep changing.
    load(32'h0000_3004, 3'd3);
    repeat (3) stall_cycle();
    check("hold_pc", a_pc, 32'h0000_3004);
    check("hold_tnew", 32'(b_ctrl[10:8]), 32'd2);
    check("hold_cnt", 32'(a_cnt), 32'd3);

    // Flush: instance a keeps PC/Bd, instance b takes the reset PC.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0123_4567, 32'h0000_3010, mk_ctrl(3'd5), 5'd4, 1'b1);
    check("flush_pc_a", a_pc, 32'h0000_3010);
    check("flush_bd_a", 32'(a_bd), 32'd1);
    check("flush_pc_b", b_pc, 32'h0000_3000);
    check("flush_exc_b", 32'(b_exc), 32'd0);

    // Stall and Flush on the same edge.
    load(32'h0000_3020, 3'd1);
    repeat (2) stall_cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, $urandom, 32'h0000_3024, mk_ctrl(3'd3), 5'd0, 1'b0);
    check("sf_cnt", 32'(a_cnt), 32'd0);
    check("sf_valid", 32'(a_valid), 32'd0);

    // Watchdog: threshold 4 on a, saturation at 255 and threshold 255 on b.
    load(32'h0000_3030, 3'd2);
    repeat (3) stall_cycle();
    check("wd3_tmo", 32'(a_tmo), 32'd0);
    stall_cycle();
    check("wd4_tmo", 32'(a_tmo), 32'd1);
    repeat (296) stall_cycle();
    check("wd_sat_cnt", 32'(b_cnt), 32'd255);
    check("wd_sat_tmo", 32'(b_tmo), 32'd1);
    load(32'h0000_3034, 3'd4);
    check("wd_clr_cnt", 32'(a_cnt), 32'd0);
    check("wd_clr_tmo", 32'(a_tmo), 32'd0);

    // Reset arriving mid-stall drops the held instruction.
    repeat (2) stall_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, $urandom, $urandom, mk_ctrl(3'd6), 5'd5, 1'b1);

    // Mixed random traffic.
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
            $urandom, $urandom, mk_ctrl(3'($urandom)), 5'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the hand-written per-stage registers with one block instantiated at D, E, M and W. Each instance adds a valid bit, bubble/flush injection, exception and branch-delay sideband, configurable Tnew ageing, and a stall watchdog counter. It sits between two pipeline stages and is driven by the hazard unit's Stall/Flush outputs.

## Interface
- CTRL_W, 31, control bundle width; bit layout per shared package
- TNEW_LSB, 8, LSB of Tnew field inside control bundle
- TNEW_W, 3, Tnew field width
- EXC_W, 5, exception code width
- RESET_PC, 32'h0000_3000, PC value after reset/bubble
- TNEW_MODE, 0, 0 = decrement Tnew on output path (combinational); 1 = decrement at capture (registered)
- KEEP_PC_ON_FLUSH, 1, 1 = flush captures PCIn/BdIn into the bubble; 0 = bubble gets RESET_PC/0
- STALL_MAX, 255, consecutive-stall count that raises StallTimeout

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- Stall  in  1  hold current contents
- Flush  in  1  load a bubble
- ValidIn  in  1  upstream slot holds a real instruction
- InsIn  in  32  instruction word
- PCIn  in  32  instruction PC
- CtrlIn  in  CTRL_W  control bundle
- ExcIn  in  EXC_W  exception code, 0 = none
- BdIn  in  1  instruction is in a branch delay slot
- ValidOut  out  1  registered valid
- InsOut  out  32  registered instruction
- PCOut  out  32  registered PC
- CtrlOut  out  CTRL_W  control bundle, Tnew field aged per TNEW_MODE
- ExcOut  out  EXC_W  registered exception code
- BdOut  out  1  registered delay-slot flag
- StallCnt  out  8  consecutive stall cycles, saturating
- StallTimeout  out  1  StallCnt ≥ STALL_MAX

## Operation
- Per-edge priority: Reset > Flush > Stall > load.
- Reset: Valid=0, Ins=0, PC=RESET_PC, Ctrl=0, Exc=0, Bd=0, StallCnt=0, StallTimeout=0.
- Flush (bubble): Valid=0, Ins=0, Ctrl=0, Exc=0.
  - KEEP_PC_ON_FLUSH=1: PC=PCIn, Bd=BdIn.
  - KEEP_PC_ON_FLUSH=0: PC=RESET_PC, Bd=0.
- Stall without Flush: all storage holds unchanged; Tnew is not aged during a hold.
- Load: every field takes its input. ValidIn=0 loads a bubble with the same rules as Flush.
- Tnew ageing, saturating at 0, never wraps:
  - TNEW_MODE=0: stored Tnew = CtrlIn Tnew; output Tnew = stored==0 ? 0 : stored−1.
  - TNEW_MODE=1: stored Tnew = CtrlIn Tnew==0 ? 0 : CtrlIn Tnew−1; output = stored.
  - Observable CtrlOut is identical in both modes after a load. Only the register contents differ.
- All CtrlOut bits outside [TNEW_LSB+TNEW_W-1:TNEW_LSB] pass through untouched.
- Stall watchdog:
  - StallCnt increments on each edge with Stall=1, Flush=0, Reset=0, saturating at 255.
  - Any non-stall edge (load or Flush) clears it to 0.
  - StallTimeout is registered and sticky until Reset or a non-stall edge.

## Timing
- Latency 1 cycle, input to output, on load.
- Flush and Stall both sampled at the rising edge; the effect is visible after that edge.
- Stall and Flush asserted together: Flush wins, StallCnt cleared.
- Reset mid-stall: cleared on that edge; the held instruction is lost.
- StallTimeout asserts on the edge where StallCnt becomes ≥ STALL_MAX.
- No combinational path from Stall/Flush to outputs.
- TNEW_MODE=0 has one decrementer on the CtrlOut output path.

## Structure
- Shared package:
  - control-bundle bit positions (MemWrite…CmpOp, Tnew/TUse offsets)
  - CTRL_LEN
  - exception code constants (EXC_NONE=0)
  - RESET_PC default
- One sub-module, `tnew_sat_dec`: TNEW_W-bit saturating decrement, combinational. Used in either mode.
- Watchdog counter is inline.

## Test plan
- **Reset:** assert Reset with arbitrary inputs → next edge PCOut=0x3000, Ins/Ctrl/Exc/Valid/StallCnt all 0.
- **Load:** load CtrlIn Tnew=2, then Tnew=0, in both TNEW_MODEs → CtrlOut Tnew 1, then 0; no wrap to 7; other ctrl bits equal CtrlIn.
- **Stall hold:** load PC=0x3004, then Stall 3 cycles while inputs change → PCOut stays 0x3004, Tnew unchanged, StallCnt=3.
- **Flush:** PCIn=0x3010, BdIn=1, Exc=4, KEEP_PC_ON_FLUSH=1 → Valid=0, Ins=0, Ctrl=0, Exc=0, PCOut=0x3010, BdOut=1.
  - Same stimulus with KEEP_PC_ON_FLUSH=0 → PCOut=0x3000, BdOut=0.
- **Stall+Flush same edge:** → bubble loaded, StallCnt=0.
- **Watchdog:** STALL_MAX=4; stall 4 cycles → StallTimeout=1 after 4th edge; stall 300 cycles → StallCnt saturates at 255; one load edge → StallCnt=0, StallTimeout=0.
